// File: rtl/axis_gen_pkg.sv
// Shared encodings for the AXI-Stream frame generator: pattern modes, FSM states
// and a maximal-length Fibonacci LFSR tap table indexed by register width.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    MODE_LINE  = 2'd0,
    MODE_FRAME = 2'd1,
    MODE_CONST = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LGAP   = 2'd2,
    ST_FGAP   = 2'd3
  } state_e;

  // Builds a tap mask from 1-based tap positions; a position of 0 means unused.
  function automatic logic [63:0] tap4(input int a, input int b, input int c, input int d);
    logic [63:0] m;
    m = '0;
    if (a > 0) m = m | (64'd1 << (a - 1));
    if (b > 0) m = m | (64'd1 << (b - 1));
    if (c > 0) m = m | (64'd1 << (c - 1));
    if (d > 0) m = m | (64'd1 << (d - 1));
    return m;
  endfunction

  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:  return tap4(8, 6, 5, 4);    9:  return tap4(9, 5, 0, 0);
      10: return tap4(10, 7, 0, 0);   11: return tap4(11, 9, 0, 0);
      12: return tap4(12, 6, 4, 1);   13: return tap4(13, 4, 3, 1);
      14: return tap4(14, 5, 3, 1);   15: return tap4(15, 14, 0, 0);
      16: return tap4(16, 15, 13, 4); 17: return tap4(17, 14, 0, 0);
      18: return tap4(18, 11, 0, 0);  19: return tap4(19, 6, 2, 1);
      20: return tap4(20, 17, 0, 0);  21: return tap4(21, 19, 0, 0);
      22: return tap4(22, 21, 0, 0);  23: return tap4(23, 18, 0, 0);
      24: return tap4(24, 23, 22, 17); 25: return tap4(25, 22, 0, 0);
      26: return tap4(26, 6, 2, 1);   27: return tap4(27, 5, 2, 1);
      28: return tap4(28, 25, 0, 0);  29: return tap4(29, 27, 0, 0);
      30: return tap4(30, 6, 4, 1);   31: return tap4(31, 28, 0, 0);
      32: return tap4(32, 22, 2, 1);  33: return tap4(33, 20, 0, 0);
      34: return tap4(34, 27, 2, 1);  35: return tap4(35, 33, 0, 0);
      36: return tap4(36, 25, 0, 0);  37: return tap4(37, 5, 4, 3) | tap4(2, 1, 0, 0);
      38: return tap4(38, 6, 5, 1);   39: return tap4(39, 35, 0, 0);
      40: return tap4(40, 38, 21, 19); 41: return tap4(41, 38, 0, 0);
      42: return tap4(42, 41, 20, 19); 43: return tap4(43, 42, 38, 37);
      44: return tap4(44, 43, 18, 17); 45: return tap4(45, 44, 42, 41);
      46: return tap4(46, 45, 26, 25); 47: return tap4(47, 42, 0, 0);
      48: return tap4(48, 47, 21, 20); 49: return tap4(49, 40, 0, 0);
      50: return tap4(50, 49, 24, 23); 51: return tap4(51, 50, 36, 35);
      52: return tap4(52, 49, 0, 0);  53: return tap4(53, 52, 38, 37);
      54: return tap4(54, 53, 18, 17); 55: return tap4(55, 31, 0, 0);
      56: return tap4(56, 55, 35, 34); 57: return tap4(57, 50, 0, 0);
      58: return tap4(58, 39, 0, 0);  59: return tap4(59, 58, 38, 37);
      60: return tap4(60, 59, 0, 0);  61: return tap4(61, 60, 46, 45);
      62: return tap4(62, 61, 6, 5);  63: return tap4(63, 62, 0, 0);
      64: return tap4(64, 63, 61, 60);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/axis_lfsr.sv
// Fibonacci LFSR (XOR feedback, shifts toward the MSB); load forces the all-ones
// seed and wins over advance.
module axis_lfsr
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] lfsr_value
);
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] state_reg;
  logic [DATA_WIDTH-1:0] tap_bits;
  logic                  feedback;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_tap
    assign tap_bits[gi] = state_reg[gi] & TAPS[gi];
  end

  assign feedback   = ^tap_bits;
  assign lfsr_value = state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= '1;
    end else if (load) begin
      state_reg <= '1;
    end else if (advance) begin
      state_reg <= {state_reg[DATA_WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream test-frame source: LINES lines of LINE_LEN beats with programmable
// inter-line and inter-frame gaps and four payload patterns.
module axis_frame_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_LEN   = 1024,
  parameter int LINES      = 1,
  parameter int LINE_GAP   = 16,
  parameter int FRAME_GAP  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  frame_done
);
  localparam int BEAT_W = $clog2(LINE_LEN);
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int LGAP_W = $clog2((LINE_GAP > 1) ? LINE_GAP : 1) + 1;
  localparam int FGAP_W = $clog2((FRAME_GAP > 1) ? FRAME_GAP : 1) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_LEN - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [LGAP_W-1:0] LGAP_END  = LGAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [FGAP_W-1:0] FGAP_END  = FGAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  if (LINE_LEN < 2 || LINES < 1 || DATA_WIDTH < 8 || DATA_WIDTH > 64 ||
      LINE_GAP < 0 || FRAME_GAP < 0) begin : g_param_check
    $error("axis_frame_gen: illegal parameter value");
  end

  state_e                state_reg, state_next;
  mode_e                 mode_reg;
  logic [DATA_WIDTH-1:0] const_reg;
  logic [BEAT_W-1:0]     beat_reg;
  logic [LINE_W-1:0]     line_reg;
  logic [DATA_WIDTH-1:0] pix_reg;
  logic [LGAP_W-1:0]     lgap_reg;
  logic [FGAP_W-1:0]     fgap_reg;
  logic                  done_reg;
  logic                  frame_start;
  logic                  xfer;
  logic                  last_beat;
  logic                  last_line;
  logic [DATA_WIDTH-1:0] lfsr_value;
  logic [DATA_WIDTH-1:0] pattern;

  assign m_axis_tvalid = (state_reg == ST_ACTIVE);
  assign xfer          = m_axis_tvalid & m_axis_tready;
  assign last_beat     = (beat_reg == LAST_BEAT);
  assign last_line     = (line_reg == LAST_LINE);
  assign m_axis_tuser  = m_axis_tvalid && (beat_reg == '0) && (line_reg == '0);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tdata  = m_axis_tvalid ? pattern : '0;
  assign frame_done    = done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // enable is only consulted where a new frame could begin, so frames never truncate.
  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next  = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (xfer && last_beat) begin
          if (last_line) begin
            if (FRAME_GAP > 0) begin
              state_next = ST_FGAP;
            end else if (enable) begin
              frame_start = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (LINE_GAP > 0) begin
            state_next = ST_LGAP;
          end
        end
      end
      ST_LGAP: begin
        if (lgap_reg == LGAP_END) state_next = ST_ACTIVE;
      end
      ST_FGAP: begin
        if (fgap_reg == FGAP_END) begin
          if (enable) begin
            state_next  = ST_ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg  <= MODE_LINE;
      const_reg <= '0;
      beat_reg  <= '0;
      line_reg  <= '0;
      pix_reg   <= '0;
      lgap_reg  <= '0;
      fgap_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= xfer && last_beat && last_line;
      lgap_reg <= (state_reg == ST_LGAP) ? lgap_reg + LGAP_W'(1) : '0;
      fgap_reg <= (state_reg == ST_FGAP) ? fgap_reg + FGAP_W'(1) : '0;
      if (frame_start) begin
        mode_reg  <= mode_e'(mode);
        const_reg <= const_data;
        beat_reg  <= '0;
        line_reg  <= '0;
        pix_reg   <= '0;
      end else if (xfer) begin
        // pix_reg tracks line*LINE_LEN+beat directly, wrapping at DATA_WIDTH.
        pix_reg <= pix_reg + DATA_WIDTH'(1);
        if (last_beat) begin
          beat_reg <= '0;
          line_reg <= line_reg + LINE_W'(1);
        end else begin
          beat_reg <= beat_reg + BEAT_W'(1);
        end
      end
    end
  end

  axis_lfsr #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (frame_start),
    .advance   (xfer),
    .lfsr_value(lfsr_value)
  );

  always_comb begin
    pattern = '0;
    case (mode_reg)
      MODE_LINE:  pattern = DATA_WIDTH'(beat_reg);
      MODE_FRAME: pattern = pix_reg;
      MODE_CONST: pattern = const_reg;
      MODE_LFSR:  pattern = lfsr_value;
    endcase
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed/random bench for axis_frame_gen: a small-line instance (back-to-back
// frames) and a 200-beat instance (wrap, LFSR period, gaps) against a beat-index model.
module tb_axis_frame_gen;

  logic       clk;
  logic       a_reset, a_enable, a_tready, a_tvalid, a_tuser, a_tlast, a_done;
  logic [1:0] a_mode;
  logic [7:0] a_const, a_tdata;
  logic       b_reset, b_enable, b_tready, b_tvalid, b_tuser, b_tlast, b_done;
  logic [1:0] b_mode;
  logic [7:0] b_const, b_tdata;

  int         total = 0;
  int         bad = 0;
  logic [7:0] lfsr_seq [0:511];

  axis_frame_gen #(
    .DATA_WIDTH(8), .LINE_LEN(4), .LINES(2), .LINE_GAP(2), .FRAME_GAP(0)
  ) u_dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .mode(a_mode), .const_data(a_const),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tuser(a_tuser), .m_axis_tlast(a_tlast), .frame_done(a_done)
  );

  axis_frame_gen #(
    .DATA_WIDTH(8), .LINE_LEN(200), .LINES(2), .LINE_GAP(3), .FRAME_GAP(5)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .mode(b_mode), .const_data(b_const),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast), .frame_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected payload of the k-th beat of a frame (k counts across lines).
  function automatic logic [7:0] exp_data(input int dut, input int m, input int k,
                                          input logic [7:0] c);
    int len;
    len = (dut != 0) ? 200 : 4;
    case (m)
      0:       return 8'(k % len);
      1:       return 8'(k);
      2:       return c;
      default: return lfsr_seq[k];
    endcase
  endfunction

  task automatic sample(input int dut, output logic v, output logic u, output logic l,
                        output logic fd, output logic [7:0] d);
    if (dut == 0) begin
      v = a_tvalid; u = a_tuser; l = a_tlast; fd = a_done; d = a_tdata;
    end else begin
      v = b_tvalid; u = b_tuser; l = b_tlast; fd = b_done; d = b_tdata;
    end
  endtask

  task automatic drive_ready(input int dut, input logic r);
    if (dut == 0) a_tready = r;
    else          b_tready = r;
  endtask

  task automatic set_ctrl(input int dut, input logic en, input int m, input logic [7:0] c);
    if (dut == 0) begin
      a_enable = en; a_mode = 2'(m); a_const = c;
    end else begin
      b_enable = en; b_mode = 2'(m); b_const = c;
    end
  endtask

  // Runs one full frame starting at the current falling edge; at the chg_at-th
  // transfer the controls are rewritten (they must only affect later frames).
  task automatic run_frame(input int dut, input int m, input logic [7:0] c, input int rdy_kind,
                           input int exp_lead, input int chg_at, input logic chg_en,
                           input int chg_m, input logic [7:0] chg_c);
    int len, lgap, n, k, cyc, lead, gap, fd_extra, first_rep;
    logic seen, in_gap, held, done, r, v, u, l, fd, hu, hl;
    logic [7:0] d, hd;
    len = (dut != 0) ? 200 : 4;
    lgap = (dut != 0) ? 3 : 2;
    n = 2 * len;
    k = 0; cyc = 0; lead = 0; gap = 0; fd_extra = 0; first_rep = -1;
    seen = 0; in_gap = 0; held = 0; done = 0; hd = '0; hu = 0; hl = 0;
    while (!done && cyc < 4 * n + 64) begin
      case (rdy_kind)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      drive_ready(dut, r);
      sample(dut, v, u, l, fd, d);
      if (cyc > 0 && fd) fd_extra++;
      if (held) check("stall_hold", 64'({v, d, u, l}), 64'({1'b1, hd, hu, hl}));
      held = 0;
      if (!seen) begin
        if (!v) lead++;
        else begin
          seen = 1;
          if (exp_lead >= 0) check("lead_gap", 64'(lead), 64'(exp_lead));
        end
      end
      if (in_gap) begin
        if (!v) gap++;
        else begin
          check("line_gap", 64'(gap), 64'(lgap));
          in_gap = 0;
        end
      end
      if (v && !r) begin
        held = 1; hd = d; hu = u; hl = l;
      end
      if (v && r) begin
        $display("xfer dut=%0d mode=%0d k=%0d data=%02h user=%0b last=%0b",
                 dut, m, k, d, u, l);
        check("tdata", 64'(d), 64'(exp_data(dut, m, k, c)));
        check("tuser", 64'(u), 64'(k == 0));
        check("tlast", 64'(l), 64'((k % len) == len - 1));
        if (m == 3 && k > 0 && d == 8'hFF && first_rep < 0) first_rep = k;
        if (k == chg_at) set_ctrl(dut, chg_en, chg_m, chg_c);
        if ((k % len) == len - 1 && k != n - 1) begin
          in_gap = 1; gap = 0;
        end
        k++;
        if (k == n) done = 1;
      end
      cyc++;
      @(negedge clk);
    end
    if (!done) begin
      check("frame_timeout", 64'(k), 64'(n));
    end else begin
      sample(dut, v, u, l, fd, d);
      check("frame_done", 64'(fd), 64'd1);
    end
    check("done_once", 64'(fd_extra), 64'd0);
    if (m == 3 && n > 255) check("lfsr_period", 64'(first_rep), 64'd255);
  endtask

  task automatic idle_check(input int dut, input int ncyc);
    int vc, fc;
    logic v, u, l, fd;
    logic [7:0] d;
    vc = 0; fc = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      sample(dut, v, u, l, fd, d);
      if (v) vc++;
      if (fd) fc++;
    end
    check("idle_tvalid", 64'(vc), 64'd0);
    check("idle_done", 64'(fc), 64'd0);
  endtask

  initial begin
    logic [7:0] c1, c2, c3, c4;
    int cnt, cyc;
    lfsr_seq[0] = 8'hFF;
    for (int i = 1; i < 512; i++)
      lfsr_seq[i] = {lfsr_seq[i-1][6:0], ^(lfsr_seq[i-1] & 8'hB8)};
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);

    a_reset = 0; a_enable = 0; a_mode = 0; a_const = 0; a_tready = 0;
    b_reset = 0; b_enable = 0; b_mode = 0; b_const = 0; b_tready = 0;
    #12;
    check("reset_a", 64'({a_tvalid, a_tuser, a_tlast, a_done, a_tdata}), 64'd0);
    check("reset_b", 64'({b_tvalid, b_tuser, b_tlast, b_done, b_tdata}), 64'd0);
    @(negedge clk);
    a_reset = 1; b_reset = 1;
    @(negedge clk);
    check("idle_a", 64'(a_tvalid), 64'd0);
    check("idle_b", 64'(b_tvalid), 64'd0);

    // Small instance: back-to-back frames, mid-frame control changes apply next frame.
    set_ctrl(0, 1'b1, 0, 8'h00);
    run_frame(0, 0, 8'h00, 0, -1, 5, 1'b1, 0, 8'h00);
    run_frame(0, 0, 8'h00, 1, 0, 2, 1'b1, 2, c1);
    run_frame(0, 2, c1, 2, 0, 1, 1'b1, 1, c2);
    run_frame(0, 1, c2, 2, 0, 6, 1'b0, 3, c2);
    idle_check(0, 6);

    // Reset abandoned mid-frame at line 1 beat 2.
    set_ctrl(0, 1'b1, 0, c3);
    a_tready = 1;
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 100) begin
      if (a_tvalid && a_tready) cnt++;
      cyc++;
      @(negedge clk);
    end
    check("pre_reset_tdata", 64'({a_tvalid, a_tdata}), 64'({1'b1, 8'd2}));
    #2 a_reset = 0;
    #1 check("async_reset", 64'({a_tvalid, a_tuser, a_tlast, a_done, a_tdata}), 64'd0);
    @(negedge clk);
    a_reset = 1;
    run_frame(0, 0, c3, 0, -1, 3, 1'b1, 3, c3);
    run_frame(0, 3, c3, 2, 0, 7, 1'b0, 0, c3);
    idle_check(0, 6);

    // Large instance: counter wrap, LFSR period, frame gap, enable drop.
    set_ctrl(1, 1'b1, 1, 8'h00);
    run_frame(1, 1, 8'h00, 0, -1, 10, 1'b1, 3, 8'h00);
    run_frame(1, 3, 8'h00, 2, 5, 0, 1'b1, 2, c4);
    run_frame(1, 2, c4, 1, 5, 150, 1'b0, 0, c1);
    idle_check(1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, tdata width in bits (8..64).
REQ-002 SHALL have parameter LINE_LEN, default 1024, beats per line (>=2).
REQ-003 SHALL have parameter LINES, default 1, lines per frame (>=1).
REQ-004 SHALL have parameter LINE_GAP, default 16, idle cycles between lines of a frame (>=0).
REQ-005 SHALL have parameter FRAME_GAP, default 16, idle cycles after the last line of a frame (>=0).
REQ-006 SHALL have ports: clk  in  1  sole clock; all logic rising-edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  1 = generate frames; sampled only at frame boundaries.
REQ-009 mode  in  2  pattern select: 0 line counter, 1 frame counter, 2 constant, 3 LFSR.
REQ-010 const_data  in  DATA_WIDTH  payload for mode 2.
REQ-011 m_axis_tdata  out  DATA_WIDTH  beat payload.
REQ-012 m_axis_tvalid  out  1  beat valid.
REQ-013 m_axis_tready  in  1  sink ready.
REQ-014 m_axis_tuser  out  1  start of frame, first beat only.
REQ-015 m_axis_tlast  out  1  end of line, last beat of every line.
REQ-016 frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted.

Function
REQ-017 A beat SHALL transfer only on a cycle with tvalid=1 and tready=1.
REQ-018 Once tvalid=1, tvalid, tdata, tuser and tlast SHALL hold stable until the transfer; tready SHALL NOT combinationally drive any output.
REQ-019 FSM states SHALL be IDLE, ACTIVE, LGAP, FGAP.
REQ-020 IDLE: tvalid=0; enable=1 -> ACTIVE next cycle, with mode latched and beat/line counters cleared.
REQ-021 ACTIVE: tvalid=1; on transfer, beat counter increments; on transfer of beat LINE_LEN-1: last line -> FGAP, else -> LGAP (or stay ACTIVE if LINE_GAP=0); line counter increments.
REQ-022 LGAP SHALL hold tvalid=0 for exactly LINE_GAP cycles, then -> ACTIVE.
REQ-023 FGAP SHALL hold tvalid=0 for exactly FRAME_GAP cycles, then -> ACTIVE if enable=1 (new frame, mode re-latched), else IDLE; FRAME_GAP=0 with enable=1 SHALL give back-to-back frames.
REQ-024 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-025 tuser SHALL be 1 exactly on beat 0 of line 0; tlast exactly on beat LINE_LEN-1 of every line; both are 1 on that beat when LINE_LEN=1 is disallowed (parameter check).
REQ-026 Mode 0 tdata SHALL equal the beat index within the line, truncated to DATA_WIDTH.
REQ-027 Mode 1 tdata SHALL equal line*LINE_LEN+beat, truncated to DATA_WIDTH (wraps modulo 2^DATA_WIDTH).
REQ-028 Mode 2 tdata SHALL equal const_data sampled at frame start.
REQ-029 Mode 3 tdata SHALL be a Fibonacci LFSR of DATA_WIDTH bits, seeded all-ones at each frame start, advanced only on transfer.
REQ-030 mode changes mid-frame SHALL take effect at the next frame start only.
REQ-031 frame_done SHALL assert the cycle after the final beat's transfer, for one cycle.
REQ-032 Gap counters SHALL be sized $clog2(max(gap,1))+1; beat/line counters $clog2 of LINE_LEN/LINES.

Reset
REQ-033 reset=0 SHALL force IDLE and clear tvalid, tuser, tlast, frame_done, tdata, all counters, immediately and asynchronously.
REQ-034 Reset mid-frame SHALL abandon the frame; the next frame after release SHALL start with tuser=1, beat 0.
REQ-035 Reset release SHALL be synchronised externally; the block treats it as clean.

Structure
REQ-036 Mode encodings, FSM state encodings and LFSR tap table per DATA_WIDTH SHALL live in shared package axis_gen_pkg.
REQ-037 The LFSR SHALL be a separate sub-module axis_lfsr (DATA_WIDTH parameter, seed load, advance enable).

Verification
REQ-038 LINE_LEN=4, LINES=2, LINE_GAP=2, mode 0, tready=1 -> data 0,1,2,3,gap2,0,1,2,3; tuser on first beat; tlast on each 3; frame_done once.
REQ-039 Same, tready toggling 1010 -> identical beat sequence, outputs stable while stalled, no dropped/duplicated beats.
REQ-040 mode 1, DATA_WIDTH=8, LINE_LEN=200, LINES=2 -> line 1 data 200..255,0..143 (wrap).
REQ-041 reset=0 asserted at beat 2 of line 1 -> outputs 0 same cycle; after release with enable=1 -> tuser=1, tdata=0.
REQ-042 enable dropped mid-frame, FRAME_GAP=0 -> frame completes, then IDLE with tvalid=0; mode changed mid-frame takes effect next frame only.
REQ-043 mode 3, DATA_WIDTH=8 -> first beat 0xFF, sequence matches reference LFSR model, period 255.
